// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between ICache line reads and DCache line reads/writes.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants when both caches request together (default: DCache first).
module mem_arbiter #(
    parameter int LINE_WORDS  = 4,
    parameter int MEM_LATENCY = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_gnt,
    output logic              ic_rvalid,
    output logic [DATA_W-1:0] ic_rdata,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [DATA_W-1:0] dc_wdata,
    output logic              dc_wready,
    output logic              dc_gnt,
    output logic              dc_rvalid,
    output logic [DATA_W-1:0] dc_rdata,
    output logic              dc_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(MEM_LATENCY - 1);
    localparam logic              OWNER_IC  = 1'b0;
    localparam logic              OWNER_DC  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_s;
    logic                owner_r;
    logic                owner_s;
    logic                we_r;
    logic                we_s;
    logic [ADDR_W-1:0]   base_r;
    logic [ADDR_W-1:0]   base_s;
    logic [BEAT_W-1:0]   beat_r;
    logic [BEAT_W-1:0]   beat_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_s;
    logic                pick_dc_s;
    logic                capture_s;
    logic                issue_s;
    logic                active_s;

    // Clearing the word-offset bits keeps every beat inside the requested line.
    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(LINE_WORDS - 1);
    endfunction

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_winner_r;

    // Winner on a tie is whichever cache did not win the previous grant.
    always_comb begin
        pick_dc_s = 1'b0;
        if (ic_req && dc_req) begin
            pick_dc_s = (last_winner_r == OWNER_IC);
        end else begin
            pick_dc_s = dc_req;
        end
    end

    // Remember the owner of every new grant.
    always_ff @(posedge clock) begin
        if (!reset) begin
            last_winner_r <= OWNER_IC;
        end else if ((state_r == IDLE) && (state_s == ISSUE)) begin
            last_winner_r <= owner_s;
        end else begin
            last_winner_r <= last_winner_r;
        end
    end
`else
    // Fixed priority: DCache always wins a tie.
    always_comb begin
        pick_dc_s = 1'b0;
        pick_dc_s = dc_req;
    end
`endif

    // Next-state logic: per beat one issue cycle, then MEM_LATENCY wait cycles.
    always_comb begin
        state_s   = state_r;
        owner_s   = owner_r;
        we_s      = we_r;
        base_s    = base_r;
        beat_s    = beat_r;
        cnt_s     = cnt_r;
        capture_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (ic_req || dc_req) begin
                    owner_s = pick_dc_s ? OWNER_DC : OWNER_IC;
                    we_s    = pick_dc_s ? dc_we : 1'b0;
                    base_s  = pick_dc_s ? line_base(dc_addr) : line_base(ic_addr);
                    beat_s  = {BEAT_W{1'b0}};
                    cnt_s   = {CNT_W{1'b0}};
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                cnt_s   = CNT_LOAD;
                state_s = WAIT;
            end
            WAIT: begin
                if (cnt_r != {CNT_W{1'b0}}) begin
                    cnt_s = cnt_r - CNT_W'(1);
                end else begin
                    // mem_rdata is valid in this cycle for the beat issued MEM_LATENCY ago.
                    capture_s = ~we_r;
                    if (beat_r == LAST_BEAT) begin
                        state_s = DONE;
                    end else begin
                        beat_s  = beat_r + BEAT_W'(1);
                        state_s = ISSUE;
                    end
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Decode of the upcoming state, used to register all outputs.
    always_comb begin
        issue_s  = 1'b0;
        active_s = 1'b0;
        issue_s  = (state_s == ISSUE);
        active_s = (state_s != IDLE);
    end

    // Transaction state registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= IDLE;
            owner_r <= OWNER_IC;
            we_r    <= 1'b0;
            base_r  <= {ADDR_W{1'b0}};
            beat_r  <= {BEAT_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            we_r    <= we_s;
            base_r  <= base_s;
            beat_r  <= beat_s;
            cnt_r   <= cnt_s;
        end
    end

    // Registered outputs, computed from the state being entered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            busy      <= 1'b0;
            ic_gnt    <= 1'b0;
            dc_gnt    <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {ADDR_W{1'b0}};
            mem_wdata <= {DATA_W{1'b0}};
            dc_wready <= 1'b0;
            ic_rvalid <= 1'b0;
            dc_rvalid <= 1'b0;
            ic_rdata  <= {DATA_W{1'b0}};
            dc_rdata  <= {DATA_W{1'b0}};
            ic_done   <= 1'b0;
            dc_done   <= 1'b0;
        end else begin
            busy      <= active_s;
            ic_gnt    <= active_s && (owner_s == OWNER_IC);
            dc_gnt    <= active_s && (owner_s == OWNER_DC);
            mem_req   <= issue_s;
            mem_we    <= issue_s && we_s;
            mem_addr  <= issue_s ? (base_s | ADDR_W'(beat_s)) : {ADDR_W{1'b0}};
            // The DCache holds the current word until it sees dc_wready, so this is the beat's data.
            mem_wdata <= (issue_s && we_s) ? dc_wdata : {DATA_W{1'b0}};
            dc_wready <= issue_s && we_s;
            ic_rvalid <= capture_s && (owner_r == OWNER_IC);
            dc_rvalid <= capture_s && (owner_r == OWNER_DC);
            ic_rdata  <= (capture_s && (owner_r == OWNER_IC)) ? mem_rdata : ic_rdata;
            dc_rdata  <= (capture_s && (owner_r == OWNER_DC)) ? mem_rdata : dc_rdata;
            ic_done   <= (state_s == DONE) && (owner_s == OWNER_IC);
            dc_done   <= (state_s == DONE) && (owner_s == OWNER_DC);
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a line-level timeline model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_mem_arbiter;

    localparam int LW   = 4;
    localparam int LAT  = 2;
    localparam int XFER = LW * (1 + LAT) + 1;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ic_req = 1'b0;
    logic [31:0] ic_addr = 32'h0;
    logic        ic_gnt, ic_rvalid, ic_done;
    logic [31:0] ic_rdata;
    logic        dc_req = 1'b0;
    logic        dc_we = 1'b0;
    logic [31:0] dc_addr = 32'h0;
    logic [31:0] dc_wdata = 32'h0;
    logic        dc_wready, dc_gnt, dc_rvalid, dc_done;
    logic [31:0] dc_rdata;
    logic        mem_req, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    bit          armed = 1'b0;
    logic [31:0] mem_arr [0:255];
    logic [31:0] wr_words [0:3];

    mem_arbiter #(.LINE_WORDS(LW), .MEM_LATENCY(LAT), .ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt), .ic_rvalid(ic_rvalid),
        .ic_rdata(ic_rdata), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_wready(dc_wready), .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid),
        .dc_rdata(dc_rdata), .dc_done(dc_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    // Memory: data appears LAT cycles after the request, reads return the stored word.
    initial begin
        int          due_q[$];
        logic [7:0]  adr_q[$];
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'hA0 + i;
        forever begin
            @(negedge clock);
            if (mem_req === 1'b1) begin
                if (mem_we === 1'b1) mem_arr[mem_addr[7:0]] = mem_wdata;
                due_q.push_back(cyc + LAT);
                adr_q.push_back(mem_addr[7:0]);
            end
            while (due_q.size() > 0 && due_q[0] < cyc) begin
                void'(due_q.pop_front());
                void'(adr_q.pop_front());
            end
            mem_rdata = 32'hDEAD_BEEF;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                mem_rdata = mem_arr[adr_q[0]];
                void'(due_q.pop_front());
                void'(adr_q.pop_front());
            end
        end
    end

    // Line-level model: each grant fixes a timeline relative to its decision cycle.
    initial begin
        bit          m_act, m_dc, m_we, m_last_dc, pick;
        int          m_t0, d, k;
        logic [31:0] m_base, e_data;
        logic        e_act, e_iss, e_rv, e_done;
        m_act = 1'b0; m_dc = 1'b0; m_we = 1'b0; m_last_dc = 1'b0; m_t0 = 0; m_base = 32'h0;
        forever begin
            @(negedge clock);
            if (armed) begin
                d      = cyc - m_t0;
                e_act  = m_act && (d >= 1) && (d <= XFER);
                e_iss  = e_act && (d < XFER) && (((d - 1) % (LAT + 1)) == 0);
                e_rv   = e_act && !m_we && (d >= LAT + 2) && (((d - 1) % (LAT + 1)) == 0);
                e_done = e_act && (d == XFER);
                k      = (d - 1) / (LAT + 1);
                chk("busy", busy, e_act);
                chk("ic_gnt", ic_gnt, e_act && !m_dc);
                chk("dc_gnt", dc_gnt, e_act && m_dc);
                chk("mem_req", mem_req, e_iss);
                chk("dc_wready", dc_wready, e_iss && m_we);
                chk("ic_rvalid", ic_rvalid, e_rv && !m_dc);
                chk("dc_rvalid", dc_rvalid, e_rv && m_dc);
                chk("ic_done", ic_done, e_done && !m_dc);
                chk("dc_done", dc_done, e_done && m_dc);
                if (e_iss) begin
                    chk("mem_addr", mem_addr, m_base + k);
                    chk("mem_we", mem_we, m_we);
                    if (m_we) chk("mem_wdata", mem_wdata, wr_words[k]);
                end
                if (e_rv) begin
                    e_data = mem_arr[8'(m_base + k - 1)];
                    if (m_dc) chk("dc_rdata", dc_rdata, e_data);
                    else      chk("ic_rdata", ic_rdata, e_data);
                end
                if (reset == 1'b0) begin
                    m_act     = 1'b0;
                    m_last_dc = 1'b0;
                end else if (!m_act || d > XFER) begin
                    m_act = 1'b0;
                    if (ic_req || dc_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        pick = (ic_req && dc_req) ? !m_last_dc : dc_req;
`else
                        pick = dc_req;
`endif
                        m_act     = 1'b1;
                        m_t0      = cyc;
                        m_dc      = pick;
                        m_we      = pick ? dc_we : 1'b0;
                        m_base    = (pick ? dc_addr : ic_addr) & ~32'(LW - 1);
                        m_last_dc = pick;
                    end
                end
            end
        end
    end

    task automatic wait_done(input bit want_dc);
        bit got;
        got = 1'b0;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clock);
            if (want_dc ? dc_done : ic_done) got = 1'b1;
        end
        chk(want_dc ? "dc_done_seen" : "ic_done_seen", got, 1'b1);
    endtask

    task automatic test_ic_alone();
        int          rq_d[$], rv_d[$];
        logic [31:0] rq_a[$], rv_v[$];
        int          dn_d;
        int          exp_rq_d[4] = '{1, 4, 7, 10};
        int          exp_rv_d[4] = '{4, 7, 10, 13};
        logic [31:0] exp_rq_a[4] = '{32'h10, 32'h11, 32'h12, 32'h13};
        logic [31:0] exp_rv_v[4] = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        dn_d = -1;
        @(posedge clock); #1;
        ic_addr = 32'h13; ic_req = 1'b1;
        for (int d = 1; d <= XFER + 1; d++) begin
            @(posedge clock); #1;
            if (d == XFER + 1) ic_req = 1'b0;
            @(negedge clock);
            if (mem_req) begin rq_d.push_back(d); rq_a.push_back(mem_addr); end
            if (ic_rvalid) begin rv_d.push_back(d); rv_v.push_back(ic_rdata); end
            if (ic_done) dn_d = d;
            if (d == XFER + 1) chk("t1_busy_after_done", busy, 1'b0);
        end
        chk("t1_req_count", rq_d.size(), 32'd4);
        chk("t1_rvalid_count", rv_d.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < rq_d.size()) begin
                chk("t1_req_cycle", rq_d[i], exp_rq_d[i]);
                chk("t1_req_addr", rq_a[i], exp_rq_a[i]);
            end
            if (i < rv_d.size()) begin
                chk("t1_rvalid_cycle", rv_d[i], exp_rv_d[i]);
                chk("t1_rdata", rv_v[i], exp_rv_v[i]);
            end
        end
        chk("t1_done_cycle", dn_d, 32'd13);
    endtask

    task automatic test_same_cycle();
        bit ic_hi, got;
        ic_hi = 1'b0; got = 1'b0;
        @(posedge clock); #1;
        ic_addr = 32'h08; dc_addr = 32'h40; dc_we = 1'b0; ic_req = 1'b1; dc_req = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        chk("t2_dc_first", dc_gnt, 1'b1);
        chk("t2_ic_not_first", ic_gnt, 1'b0);
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clock);
            if (ic_gnt) ic_hi = 1'b1;
            if (dc_done) got = 1'b1;
        end
        chk("t2_dc_done_seen", got, 1'b1);
        chk("t2_ic_held_off", ic_hi, 1'b0);
        @(posedge clock); #1;
        dc_req = 1'b0;
        @(negedge clock);
        chk("t2_idle_cycle_gnt", ic_gnt, 1'b0);
        @(posedge clock); #1;
        @(negedge clock);
        chk("t2_ic_gnt", ic_gnt, 1'b1);
        chk("t2_ic_first_addr", mem_addr, 32'h08);
        wait_done(1'b0);
        @(posedge clock); #1;
        ic_req = 1'b0;
    endtask

    task automatic test_dc_write();
        int widx, rv_cnt, dn_cnt;
        bit got;
        widx = 0; rv_cnt = 0; dn_cnt = 0; got = 1'b0;
        @(posedge clock); #1;
        dc_addr = 32'h21; dc_we = 1'b1; dc_wdata = wr_words[0]; dc_req = 1'b1;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clock);
            if (dc_rvalid) rv_cnt++;
            if (dc_done) begin dn_cnt++; got = 1'b1; end
            if (dc_wready) begin
                widx++;
                @(posedge clock); #1;
                dc_wdata = wr_words[(widx > 3) ? 3 : widx];
            end
        end
        @(posedge clock); #1;
        dc_req = 1'b0; dc_we = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clock);
            if (dc_rvalid) rv_cnt++;
            if (dc_done) dn_cnt++;
        end
        chk("t3_wready_count", widx, 32'd4);
        chk("t3_no_rvalid", rv_cnt, 32'd0);
        chk("t3_done_once", dn_cnt, 32'd1);
        chk("t3_mem_20", mem_arr[8'h20], 32'h11);
        chk("t3_mem_21", mem_arr[8'h21], 32'h22);
        chk("t3_mem_22", mem_arr[8'h22], 32'h33);
        chk("t3_mem_23", mem_arr[8'h23], 32'h44);
    endtask

    task automatic test_reset_mid();
        @(posedge clock); #1;
        ic_addr = 32'h35; ic_req = 1'b1;
        for (int d = 1; d <= 7; d++) begin
            @(posedge clock); #1;
        end
        @(negedge clock);
        chk("t4_beat2_req", mem_req, 1'b1);
        chk("t4_beat2_addr", mem_addr, 32'h36);
        @(posedge clock); #1;
        reset = 1'b0; ic_req = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        chk("t4_rst_mem_req", mem_req, 1'b0);
        chk("t4_rst_ic_gnt", ic_gnt, 1'b0);
        chk("t4_rst_busy", busy, 1'b0);
        chk("t4_rst_ic_done", ic_done, 1'b0);
        chk("t4_rst_mem_addr", mem_addr, 32'h0);
        @(posedge clock); #1;
        ic_req = 1'b1;
        @(posedge clock); #1;
        @(negedge clock);
        chk("t4_restart_req", mem_req, 1'b1);
        chk("t4_restart_addr", mem_addr, 32'h34);
        wait_done(1'b0);
        @(posedge clock); #1;
        ic_req = 1'b0;
    endtask

    task automatic test_both_held();
        bit got, winner;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        bit exp_w[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        bit exp_w[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        @(posedge clock); #1;
        ic_addr = 32'h50; dc_addr = 32'h60; dc_we = 1'b0; ic_req = 1'b1; dc_req = 1'b1;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0; winner = 1'b0;
            for (int n = 0; n < 64 && !got; n++) begin
                @(negedge clock);
                if (ic_done || dc_done) begin got = 1'b1; winner = dc_done; end
            end
            chk("t5_done_seen", got, 1'b1);
            chk("t5_winner_is_dc", winner, exp_w[g]);
        end
        @(posedge clock); #1;
        ic_req = 1'b0; dc_req = 1'b0;
    endtask

    task automatic test_dc_drop();
        int  rv_cnt, dn_d;
        logic [31:0] last_v;
        bit  got;
        rv_cnt = 0; dn_d = -1; got = 1'b0; last_v = 32'h0;
        @(posedge clock); #1;
        dc_addr = 32'h45; dc_we = 1'b0; dc_req = 1'b1;
        for (int d = 1; d <= 40 && !got; d++) begin
            @(posedge clock); #1;
            if (d == 5) dc_req = 1'b0;
            @(negedge clock);
            if (dc_rvalid) begin rv_cnt++; last_v = dc_rdata; end
            if (dc_done) begin dn_d = d; got = 1'b1; end
        end
        chk("t6_rvalid_count", rv_cnt, 32'd4);
        chk("t6_done_cycle", dn_d, 32'd13);
        chk("t6_last_rdata", last_v, 32'hE7);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        wr_words[0] = 32'h11; wr_words[1] = 32'h22; wr_words[2] = 32'h33; wr_words[3] = 32'h44;
        repeat (3) @(posedge clock);
        #1;
        armed = 1'b1;
        @(negedge clock);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_ic_gnt", ic_gnt, 1'b0);
        chk("rst_dc_gnt", dc_gnt, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        @(posedge clock); #1;
        reset = 1'b1;
        test_ic_alone();
        test_same_cycle();
        test_dc_write();
        test_reset_mid();
        test_both_held();
        test_dc_drop();
        repeat (4) @(posedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates one shared backing memory port between the ICache refill path and the DCache refill/writeback path.
- Each granted transaction is one full cache line, moved as LINE_WORDS single-word beats against a fixed-latency memory.
- Sits between both caches and the unified memory model. Cache stalls (iCacheStall/dCacheStall) stay asserted until the owning cache sees its done pulse.

Parameters:
- LINE_WORDS, 4, words per line; power of 2, >=1.
- MEM_LATENCY, 2, cycles from mem_req to valid mem_rdata; >=1.
- ADDR_W, 32, word-address width (caches pass PC>>2-style word addresses).
- DATA_W, 32, data word width.

Ports:
- clock  in  1  single clock, all state on posedge.
- reset  in  1  synchronous, active-low reset.
- ic_req  in  1  ICache line-read request; level, held until ic_done.
- ic_addr  in  ADDR_W  ICache miss word address.
- ic_gnt  out  1  ICache owns the memory port.
- ic_rvalid  out  1  one-cycle pulse per returned word.
- ic_rdata  out  DATA_W  returned word, valid with ic_rvalid.
- ic_done  out  1  one-cycle pulse at end of the ICache transaction.
- dc_req  in  1  DCache request; level, held until dc_done.
- dc_we  in  1  1 = line write, 0 = line read; sampled at grant.
- dc_addr  in  ADDR_W  DCache word address.
- dc_wdata  in  DATA_W  current write beat data.
- dc_wready  out  1  write beat consumed; DCache advances to the next word.
- dc_gnt, dc_rvalid, dc_rdata, dc_done  out  1/1/DATA_W/1  same meaning as the ic_* outputs.
- mem_req  out  1  one-cycle issue pulse per beat.
- mem_we  out  1  write qualifier for mem_req.
- mem_addr  out  ADDR_W  beat word address.
- mem_wdata  out  DATA_W  beat write data.
- mem_rdata  in  DATA_W  valid exactly MEM_LATENCY cycles after mem_req.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE, beat=0, cnt=0, owner cleared.
  - All outputs 0 from the next cycle.
  - Any in-flight transaction is abandoned, with no done pulse.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any request is high, pick a winner per the priority rule.
  - Latch owner, we (0 for ICache), and base = addr with low log2(LINE_WORDS) bits cleared; set beat=0.
  - Go to ISSUE.
  - The owner's gnt is registered high from ISSUE entry through DONE inclusive.
- ISSUE:
  - mem_req=1, mem_addr=base|beat, mem_we=owner_we.
  - If writing: mem_wdata=dc_wdata and dc_wready=1 for this cycle.
  - cnt<=MEM_LATENCY-1; go to WAIT.
- WAIT:
  - If cnt!=0, decrement.
  - If cnt==0, mem_rdata is valid this cycle. For a read, register it to xx_rdata and pulse xx_rvalid in the following cycle; writes produce no rvalid.
  - On cnt==0: if beat==LINE_WORDS-1 go to DONE, else beat++ and go to ISSUE.
- DONE:
  - Pulse xx_done for one cycle.
  - The final read's rvalid coincides with done.
  - Clear gnt; go to IDLE.
  - Requests are re-sampled only in IDLE, so the requester drops req in the cycle after done.
- Timing:
  - Each beat costs 1+MEM_LATENCY cycles.
  - Grant-to-done = LINE_WORDS*(1+MEM_LATENCY)+1 cycles, with the grant decision in cycle 0.
- Boundary conditions:
  - req deasserting mid-transaction is ignored; the line always completes (no abort).
  - Requests from the non-owner are held off without loss and are evaluated at the next IDLE.
  - Addresses never cross a line boundary, since base is aligned and beat < LINE_WORDS.
  - Same-cycle requests from both caches resolve via the priority rule only.
- Priority (default): fixed, DCache over ICache.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_winner register, reset to ICache.
  - When both requests are high in IDLE, grant the requester that is not last_winner.
  - last_winner updates on each grant.
- Undefined: the fixed DCache-first rule applies, and no last_winner register exists.

Test Plan:
- ICache read alone (LINE_WORDS=4, MEM_LATENCY=2, ic_addr=0x13, grant decided in cycle 0; the memory model returns 0xA0+addr):
  - mem_req at cycles 1,4,7,10 with mem_addr 0x10..0x13.
  - ic_rvalid at 4,7,10,13 carrying 0xB0..0xB3.
  - ic_done at 13; busy=0 at 14.
- ic_req and dc_req rise in the same cycle (macro off):
  - dc_gnt first; ic_gnt is 0 until dc_done.
  - ICache is then granted in the following IDLE cycle.
- DCache write to dc_addr=0x21 with dc_we=1, data stepping 0x11,0x22,0x33,0x44 on each dc_wready:
  - mem_we=1 writes to 0x20..0x23 with those words.
  - No dc_rvalid pulses; dc_done pulses once.
- reset driven low during beat 2 of an ICache read:
  - Next cycle mem_req, ic_gnt, busy and ic_done are all 0.
  - After release, a new ic_req starts at beat 0 (mem_addr = base).
- Both requests held continuously, done acknowledged each time:
  - With MEM_ARB_ROUND_ROBIN_EN, grants go dc,ic,dc,ic.
  - Without it, dc is granted every time.
- dc_req dropped during WAIT of beat 1 (read): all 4 dc_rvalid pulses and dc_done are still produced.
